// File: rtl/cpu_pkg.sv
// Shared types and constants for the execute-stage hazard controller.
// Holds the controller FSM state encoding, the forwarding-select type and
// its three legal values, and the index of the hard-wired zero register.
package cpu_pkg;

    // XZR reads as zero and discards writes, so it never creates a dependency
    localparam int unsigned XZR         = 31;
    // Wide enough for a squash length of up to 3 cycles
    localparam int unsigned FLUSH_CNT_W = 2;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } hz_state_e;

    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_RF  = 2'b00;
    localparam fwd_sel_t FWD_WB  = 2'b01;
    localparam fwd_sel_t FWD_MEM = 2'b10;

endpackage

// File: rtl/ex_hazard_ctrl_if.sv
// Pipeline <-> hazard controller bundle.
// master : pipeline side, drives the stage register indices / control bits
//          and receives forwarding selects and hold/flush/bubble controls.
// slave  : the hazard controller.
// Optional HAZ_STATS_EN adds the stall_cnt / flush_cnt statistics outputs.
interface ex_hazard_ctrl_if #(
    parameter int unsigned REG_W = 5
) ();
    import cpu_pkg::*;

    logic [REG_W-1:0] id_rn;
    logic [REG_W-1:0] id_rm;
    logic             id_use_rn;
    logic             id_use_rm;
    logic             id_use_flags;
    logic [REG_W-1:0] ex_rn;
    logic [REG_W-1:0] ex_rm;
    logic [REG_W-1:0] ex_rd;
    logic             ex_regwrite;
    logic             ex_memread;
    logic             ex_update;
    logic [REG_W-1:0] mem_rd;
    logic             mem_regwrite;
    logic [REG_W-1:0] wb_rd;
    logic             wb_regwrite;
    logic             br_taken;

    fwd_sel_t         fwd_a;
    fwd_sel_t         fwd_b;
    logic             pc_hold;
    logic             ifid_hold;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             busy;
`ifdef HAZ_STATS_EN
    logic [31:0]      stall_cnt;
    logic [31:0]      flush_cnt;
`endif

    modport master (
        output id_rn, id_rm, id_use_rn, id_use_rm, id_use_flags,
        output ex_rn, ex_rm, ex_rd, ex_regwrite, ex_memread, ex_update,
        output mem_rd, mem_regwrite, wb_rd, wb_regwrite, br_taken,
        input  fwd_a, fwd_b, pc_hold, ifid_hold, ifid_flush, idex_bubble, busy
`ifdef HAZ_STATS_EN
        , input stall_cnt, flush_cnt
`endif
    );

    modport slave (
        input  id_rn, id_rm, id_use_rn, id_use_rm, id_use_flags,
        input  ex_rn, ex_rm, ex_rd, ex_regwrite, ex_memread, ex_update,
        input  mem_rd, mem_regwrite, wb_rd, wb_regwrite, br_taken,
        output fwd_a, fwd_b, pc_hold, ifid_hold, ifid_flush, idex_bubble, busy
`ifdef HAZ_STATS_EN
        , output stall_cnt, flush_cnt
`endif
    );

endinterface

// File: rtl/fwd_unit.sv
// Combinational operand-forwarding select for one ALU operand.
// Ports: en (0 forces the regfile path), src (EX operand index),
//        mem_rd/mem_regwrite, wb_rd/wb_regwrite (producers), sel (result).
// MEM is the younger producer, so it wins over WB when both match.
module fwd_unit
    import cpu_pkg::*;
#(
    parameter int unsigned REG_W    = 5,
    parameter int unsigned ZERO_REG = XZR
) (
    input  logic             en,
    input  logic [REG_W-1:0] src,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             mem_regwrite,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             wb_regwrite,
    output fwd_sel_t         sel
);

    localparam logic [REG_W-1:0] ZR = REG_W'(ZERO_REG);

    logic mem_hit_c;
    logic wb_hit_c;

    assign mem_hit_c = mem_regwrite && (mem_rd == src) && (mem_rd != ZR);
    assign wb_hit_c  = wb_regwrite  && (wb_rd  == src) && (wb_rd  != ZR);

    always_comb begin
        sel = FWD_RF;
        if (en) begin
            if (mem_hit_c) begin
                sel = FWD_MEM;
            end else if (wb_hit_c) begin
                sel = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/ex_hazard_ctrl.sv
// Execute-stage hazard controller for the 5-stage LEGv8 pipeline.
// Ports: clk, reset (sync, active-high), hz (slave side of ex_hazard_ctrl_if):
//   forwarding selects fwd_a/fwd_b, PC / IF/ID hold, IF/ID flush,
//   ID/EX bubble and busy (FSM not in RUN).
// Optional feature macro HAZ_STATS_EN: saturating stall/flush cycle counters.
module ex_hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned REG_W        = 5,
    parameter int unsigned ZERO_REG     = XZR,
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic             clk,
    input  logic             reset,
    ex_hazard_ctrl_if.slave  hz
);

    localparam logic [REG_W-1:0]       ZR         = REG_W'(ZERO_REG);
    localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

    hz_state_e              state_q, state_d;
    logic [FLUSH_CNT_W-1:0] cnt_q, cnt_d;
    logic [FLUSH_CNT_W-1:0] cnt_next_c;

    logic lu_c;
    logic fh_c;
    logic fwd_en_c;
    logic pc_hold_c;
    logic ifid_hold_c;
    logic ifid_flush_c;
    logic idex_bubble_c;
    logic busy_c;

    // Operand forwarding, one compare unit per ALU operand
    assign fwd_en_c = ~reset;

    fwd_unit #(.REG_W(REG_W), .ZERO_REG(ZERO_REG)) u_fwd_a (
        .en           (fwd_en_c),
        .src          (hz.ex_rn),
        .mem_rd       (hz.mem_rd),
        .mem_regwrite (hz.mem_regwrite),
        .wb_rd        (hz.wb_rd),
        .wb_regwrite  (hz.wb_regwrite),
        .sel          (hz.fwd_a)
    );

    fwd_unit #(.REG_W(REG_W), .ZERO_REG(ZERO_REG)) u_fwd_b (
        .en           (fwd_en_c),
        .src          (hz.ex_rm),
        .mem_rd       (hz.mem_rd),
        .mem_regwrite (hz.mem_regwrite),
        .wb_rd        (hz.wb_rd),
        .wb_regwrite  (hz.wb_regwrite),
        .sel          (hz.fwd_b)
    );

    // Load-use: the LDUR in EX produces a register the ID instruction reads
    assign lu_c = hz.ex_memread && hz.ex_regwrite && (hz.ex_rd != ZR) &&
                  ((hz.id_use_rn && (hz.id_rn == hz.ex_rd)) ||
                   (hz.id_use_rm && (hz.id_rm == hz.ex_rd)));

    // Flags are written at the end of EX, so a B.cond right behind must wait
    assign fh_c = hz.id_use_flags && hz.ex_update;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state and control outputs
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        cnt_next_c    = '0;
        pc_hold_c     = 1'b0;
        ifid_hold_c   = 1'b0;
        ifid_flush_c  = 1'b0;
        idex_bubble_c = 1'b0;
        busy_c        = 1'b0;

        if (!reset) begin
            busy_c = (state_q != RUN);
            unique case (state_q)
                // The single stall cycle is over; the pipeline re-evaluates
                // exactly as in RUN, so a fresh hazard is still honoured.
                RUN, STALL: begin
                    if (hz.br_taken) begin
                        // Squash wins: the would-be stalled instr is wrong-path
                        ifid_flush_c  = 1'b1;
                        idex_bubble_c = 1'b1;
                        cnt_d         = FLUSH_LOAD;
                        state_d       = (FLUSH_LOAD != '0) ? FLUSH : RUN;
                    end else if (lu_c || fh_c) begin
                        pc_hold_c     = 1'b1;
                        ifid_hold_c   = 1'b1;
                        idex_bubble_c = 1'b1;
                        state_d       = STALL;
                    end else begin
                        state_d       = RUN;
                    end
                end
                FLUSH: begin
                    // Hazards are ignored here: the ID instruction is squashed
                    ifid_flush_c  = 1'b1;
                    idex_bubble_c = 1'b1;
                    cnt_next_c    = hz.br_taken ? FLUSH_LOAD
                                                : (cnt_q - FLUSH_CNT_W'(1));
                    cnt_d         = cnt_next_c;
                    state_d       = (cnt_next_c == '0) ? RUN : FLUSH;
                end
                default: begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign hz.pc_hold     = pc_hold_c;
    assign hz.ifid_hold   = ifid_hold_c;
    assign hz.ifid_flush  = ifid_flush_c;
    assign hz.idex_bubble = idex_bubble_c;
    assign hz.busy        = busy_c;

`ifdef HAZ_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    // Saturating event counters
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (pc_hold_c && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (ifid_flush_c && (flush_cnt_q != 32'hFFFF_FFFF)) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hz.stall_cnt = stall_cnt_q;
    assign hz.flush_cnt = flush_cnt_q;
`endif

endmodule
